// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding and glyph codes for the start countdown
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT3,
        COUNT2,
        COUNT1,
        GO,
        RUN
    } cd_state_t;

    localparam logic [3:0] POS_BLANK = 4'd0;
    localparam logic [3:0] POS_ONE   = 4'd1;
    localparam logic [3:0] POS_TWO   = 4'd2;
    localparam logic [3:0] POS_THREE = 4'd3;
    localparam logic [3:0] POS_GO    = 4'd4;

    function automatic logic [3:0] state_pos(input cd_state_t s);
        case (s)
            COUNT3:  return POS_THREE;
            COUNT2:  return POS_TWO;
            COUNT1:  return POS_ONE;
            GO:      return POS_GO;
            default: return POS_BLANK;
        endcase
    endfunction

    function automatic logic is_counting(input cd_state_t s);
        return (s == COUNT3) || (s == COUNT2) || (s == COUNT1) || (s == GO);
    endfunction

endpackage

// File: rtl/countdown_sequencer_step_timer.sv
// rtl/countdown_sequencer_step_timer.sv - per-glyph hold counter with terminal-count compare
module step_timer #(
    parameter int TICKS_PER_STEP = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = $clog2(TICKS_PER_STEP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_STEP - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LAST);

endmodule

// File: rtl/countdown_sequencer.sv
// rtl/countdown_sequencer.sv - start-edge triggered 3-2-1-GO countdown feeding the start-screen glyph mapper
// Optional COUNTDOWN_PAUSE_EN: pause freezes the countdown while busy.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int TICKS_PER_STEP = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       game_over,
    input  logic       pause,
    output logic [3:0] STARTpos,
    output logic       game_active,
    output logic       go_pulse,
    output logic       busy
);

    cd_state_t  state_q, state_d;
    logic       start_q;
    logic [3:0] pos_q, pos_d;
    logic       active_q, active_d;
    logic       go_q, go_d;
    logic       busy_q, busy_d;
    logic       start_rise;
    logic       in_count;
    logic       hold;
    logic       tick_done;
    logic       advance;

    assign start_rise = start & ~start_q;
    assign in_count   = is_counting(state_q);

`ifdef COUNTDOWN_PAUSE_EN
    assign hold = pause & in_count;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign hold         = 1'b0;
`endif

    assign advance = tick_done & in_count & ~hold;

    step_timer #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_step_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state_d != state_q),
        .enable (in_count & ~hold),
        .done   (tick_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_rise) state_d = COUNT3;
            COUNT3:  if (advance)    state_d = COUNT2;
            COUNT2:  if (advance)    state_d = COUNT1;
            COUNT1:  if (advance)    state_d = GO;
            GO:      if (advance)    state_d = RUN;
            RUN:     if (game_over)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        pos_d    = state_pos(state_d);
        busy_d   = is_counting(state_d);
        active_d = (state_d == RUN);
        go_d     = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            pos_q    <= POS_BLANK;
            active_q <= 1'b0;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            pos_q    <= pos_d;
            active_q <= active_d;
            go_q     <= go_d;
            busy_q   <= busy_d;
        end
    end

    assign STARTpos    = pos_q;
    assign game_active = active_q;
    assign go_pulse    = go_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb/tb_countdown_sequencer.sv - self-checking bench for countdown_sequencer with TICKS_PER_STEP=4
module tb_countdown_sequencer;

    localparam int TICKS = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       game_over = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] startpos;
    logic       game_active;
    logic       go_pulse;
    logic       busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic s;
        logic g;
        logic p;
        int   pos;
        int   act;
        int   gp;
        int   bz;
    } vec_t;

    vec_t vecs[$];

    countdown_sequencer #(
        .TICKS_PER_STEP(TICKS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .game_over  (game_over),
        .pause      (pause),
        .STARTpos   (startpos),
        .game_active(game_active),
        .go_pulse   (go_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic s, input logic g, input logic p,
                        input int pos, input int act, input int gp, input int bz);
        vec_t v;
        v.s = s; v.g = g; v.p = p;
        v.pos = pos; v.act = act; v.gp = gp; v.bz = bz;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input int pos, input int act, input int gp, input int bz);
        chk({tag, "_pos"}, int'(startpos), pos);
        chk({tag, "_active"}, int'(game_active), act);
        chk({tag, "_go"}, int'(go_pulse), gp);
        chk({tag, "_busy"}, int'(busy), bz);
    endtask

    initial begin
        int n;
        int cnt3;
        int rises;
        int gos;
        int pos2;
        int go_at;
        logic prev_busy;

        // Nominal run, held start, ignored start/game_over, game over and restart.
        for (int i = 0; i < 10; i++) push(0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0);
        for (int i = 11; i <= 14; i++) push(1, 0, 0, 3, 0, 0, 1);
        push(1, 0, 0, 2, 0, 0, 1);
        push(1, 1, 0, 2, 0, 0, 1);
        push(1, 0, 0, 2, 0, 0, 1);
        push(1, 0, 0, 2, 0, 0, 1);
        push(0, 0, 0, 1, 0, 0, 1);
        push(1, 0, 0, 1, 0, 0, 1);
        push(0, 0, 0, 1, 0, 0, 1);
        push(0, 0, 0, 1, 0, 0, 1);
        for (int i = 23; i <= 26; i++) push(0, 0, 0, 4, 0, 0, 1);
        push(0, 0, 0, 0, 1, 1, 0);
        push(0, 0, 0, 0, 1, 0, 0);
        push(0, 0, 0, 0, 1, 0, 0);
        push(0, 1, 0, 0, 1, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0);
        push(1, 1, 0, 0, 0, 0, 0);
        push(1, 0, 0, 3, 0, 0, 1);
        for (int i = 34; i <= 36; i++) push(0, 0, 0, 3, 0, 0, 1);
        push(0, 0, 0, 2, 0, 0, 1);

        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].act, vecs[i].gp, vecs[i].bz);
            start     = vecs[i].s;
            game_over = vecs[i].g;
            pause     = vecs[i].p;
        end

        // Asynchronous reset in the middle of COUNT2.
        @(negedge clk);
        chk("pre_reset_pos", int'(startpos), 2);
        #2 reset_n = 1'b0;
        #1 chk_all("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= TICKS; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("post_reset_three%0d", k), int'(startpos), 3);
        end
        @(negedge clk);
        chk("post_reset_two", int'(startpos), 2);

        n = 0;
        while (!game_active && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_run_timeout", int'(game_active), 1);
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        chk("game_over_active", int'(game_active), 0);

        // Start held for 40 cycles yields a single countdown.
        @(negedge clk);
        start = 1'b1;
        cnt3 = 0; rises = 0; gos = 0; prev_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (startpos == 4'd3) cnt3++;
            if (busy && !prev_busy) rises++;
            if (go_pulse) gos++;
            prev_busy = busy;
        end
        chk("held_three_cycles", cnt3, TICKS);
        chk("held_countdowns", rises, 1);
        chk("held_go_pulses", gos, 1);
        chk("held_still_run", int'(game_active), 1);

        // game_over together with a start edge in RUN: back to idle, edge consumed.
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        chk("go_and_start_active", int'(game_active), 0);
        chk("go_and_start_busy", int'(busy), 0);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy || game_active) n++;
        end
        chk("no_rearm_cycles", n, 0);
        start = 1'b0;

        // Pause for six cycles during COUNT2.
        @(negedge clk);
        start = 1'b1;
        go_at = -1; pos2 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            pause = (k >= 6 && k <= 11);
            if (startpos == 4'd2) pos2++;
            if (go_pulse && go_at < 0) go_at = k;
        end
        pause = 1'b0;
`ifdef COUNTDOWN_PAUSE_EN
        chk("pause_two_cycles", pos2, 10);
        chk("pause_go_cycle", go_at, 4 * TICKS + 1 + 6);
`else
        chk("pause_two_cycles", pos2, TICKS);
        chk("pause_go_cycle", go_at, 4 * TICKS + 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
